// File: rtl/icb_copy_pkg.sv
// Shared definitions for the ICB block-copy master.
//   state_e      : controller states, also exported on the debug state port
//   WORD_BYTES   : address stride per 32-bit word
//   ICB_MASK_ALL : full byte-enable for 32-bit writes
package icb_copy_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_CMD = 3'd1,
        RD_RSP = 3'd2,
        WR_CMD = 3'd3,
        WR_RSP = 3'd4,
        FIN    = 3'd5
    } state_e;

    localparam int         WORD_BYTES   = 4;
    localparam logic [3:0] ICB_MASK_ALL = 4'hF;

endpackage

// File: rtl/icb_copy_addr_gen.sv
// Source/destination address and remaining-word counter for the copy master.
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture src_in/dst_in (word aligned) and len_in
//   step          : advance both addresses by one word, decrement count
//   src_in/dst_in : byte addresses; bits [1:0] are forced to zero
//   len_in        : word count to load
//   src_nxt/dst_nxt : next-cycle address values, so the top can register
//                   its ICB address output in the same edge as load/step
//   last          : current count is 1, i.e. the word in flight is the final one
module icb_copy_addr_gen
    import icb_copy_pkg::*;
#(
    parameter int AW   = 32,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [AW-1:0]   src_in,
    input  logic [AW-1:0]   dst_in,
    input  logic [LENW-1:0] len_in,
    output logic [AW-1:0]   src_nxt,
    output logic [AW-1:0]   dst_nxt,
    output logic            last
);

    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [LENW-1:0] cnt_q, cnt_d;

    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        if (load) begin
            src_d = src_in & ~AW'(3);
            dst_d = dst_in & ~AW'(3);
            cnt_d = len_in;
        end else if (step) begin
            // Plain AW-bit add: addresses wrap modulo 2^AW without complaint.
            src_d = src_q + AW'(WORD_BYTES);
            dst_d = dst_q + AW'(WORD_BYTES);
            cnt_d = cnt_q - LENW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

    assign src_nxt = src_d;
    assign dst_nxt = dst_d;
    assign last    = (cnt_q == LENW'(1));

endmodule

// File: rtl/icb_copy_master.sv
// ICB initiator copying len_words 32-bit words from src_addr to dst_addr.
// Optional feature macro: ICB_COPY_FILL_EN adds fill_mode/fill_data; with
// fill_mode=1 the read phase is skipped and every write carries fill_data.
//   clk, rst                     : clock, synchronous active-high reset
//   start, src_addr, dst_addr,
//   len_words                    : transfer request, accepted only when idle
//   busy, done, err              : status (done is a 1-cycle pulse, err sticky)
//   m_icb_cmd_*                  : ICB command channel (this block drives valid)
//   m_icb_rsp_*                  : ICB response channel (this block drives ready)
//   dbg_state                    : current controller state
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high. While cmd_valid is high and cmd_ready low, addr/read/wdata/wmask
// stay constant. Only one transaction is outstanding; rsp_ready is high only
// while waiting for that transaction's response.
//
// All outputs are registered from next-state values, so done and busy change
// on the same edge as the state they describe.
module icb_copy_master
    import icb_copy_pkg::*;
#(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            rst,
`ifdef ICB_COPY_FILL_EN
    input  logic            fill_mode,
    input  logic [DW-1:0]   fill_data,
`endif
    input  logic            start,
    input  logic [AW-1:0]   src_addr,
    input  logic [AW-1:0]   dst_addr,
    input  logic [LENW-1:0] len_words,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            m_icb_cmd_valid,
    input  logic            m_icb_cmd_ready,
    output logic [AW-1:0]   m_icb_cmd_addr,
    output logic            m_icb_cmd_read,
    output logic [DW-1:0]   m_icb_cmd_wdata,
    output logic [DW/8-1:0] m_icb_cmd_wmask,
    input  logic            m_icb_rsp_valid,
    output logic            m_icb_rsp_ready,
    input  logic            m_icb_rsp_err,
    input  logic [DW-1:0]   m_icb_rsp_rdata,
    output state_e          dbg_state
);

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   data_q, data_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
    logic            cmd_read_q, cmd_read_d;
    logic [DW-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [DW/8-1:0] cmd_wmask_q, cmd_wmask_d;
    logic            rsp_ready_q, rsp_ready_d;

    logic            ag_load, ag_step, ag_last;
    logic [AW-1:0]   ag_src_nxt, ag_dst_nxt;

    // fill_start: the request being accepted is a fill; fill_run: the
    // transfer in progress is a fill.
    logic            fill_start, fill_run;
    logic [DW-1:0]   fill_word;
`ifdef ICB_COPY_FILL_EN
    logic            fill_mode_q, fill_mode_d;
    assign fill_start = fill_mode;
    assign fill_run   = fill_mode_q;
    assign fill_word  = fill_data;
`else
    assign fill_start = 1'b0;
    assign fill_run   = 1'b0;
    assign fill_word  = '0;
`endif

    icb_copy_addr_gen #(
        .AW   (AW),
        .LENW (LENW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (ag_load),
        .step    (ag_step),
        .src_in  (src_addr),
        .dst_in  (dst_addr),
        .len_in  (len_words),
        .src_nxt (ag_src_nxt),
        .dst_nxt (ag_dst_nxt),
        .last    (ag_last)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        data_d  = data_q;
        ag_load = 1'b0;
        ag_step = 1'b0;
`ifdef ICB_COPY_FILL_EN
        fill_mode_d = fill_mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    ag_load = 1'b1;
                    err_d   = 1'b0;
`ifdef ICB_COPY_FILL_EN
                    fill_mode_d = fill_mode;
`endif
                    if (len_words == '0) begin
                        state_d = FIN;
                    end else if (fill_start) begin
                        // The fill word sits in the data register for the
                        // whole transfer; no read ever overwrites it.
                        data_d  = fill_word;
                        state_d = WR_CMD;
                    end else begin
                        state_d = RD_CMD;
                    end
                end
            end
            RD_CMD: begin
                if (m_icb_cmd_ready) state_d = RD_RSP;
            end
            RD_RSP: begin
                if (m_icb_rsp_valid) begin
                    data_d = m_icb_rsp_rdata;
                    if (m_icb_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = WR_CMD;
                    end
                end
            end
            WR_CMD: begin
                if (m_icb_cmd_ready) state_d = WR_RSP;
            end
            WR_RSP: begin
                if (m_icb_rsp_valid) begin
                    if (m_icb_rsp_err) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        ag_step = 1'b1;
                        if (ag_last)       state_d = FIN;
                        else if (fill_run) state_d = WR_CMD;
                        else               state_d = RD_CMD;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs follow the state being entered, using the address/data values
    // that become current on the same edge.
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FIN);
        cmd_valid_d = (state_d == RD_CMD) || (state_d == WR_CMD);
        cmd_read_d  = (state_d == RD_CMD);
        rsp_ready_d = (state_d == RD_RSP) || (state_d == WR_RSP);
        cmd_wmask_d = (state_d == WR_CMD) ? ICB_MASK_ALL : '0;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        if (state_d == RD_CMD) cmd_addr_d = ag_src_nxt;
        if (state_d == WR_CMD) begin
            cmd_addr_d  = ag_dst_nxt;
            cmd_wdata_d = data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_read_q  <= 1'b0;
            cmd_wdata_q <= '0;
            cmd_wmask_q <= '0;
            rsp_ready_q <= 1'b0;
`ifdef ICB_COPY_FILL_EN
            fill_mode_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            data_q      <= data_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_read_q  <= cmd_read_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_wmask_q <= cmd_wmask_d;
            rsp_ready_q <= rsp_ready_d;
`ifdef ICB_COPY_FILL_EN
            fill_mode_q <= fill_mode_d;
`endif
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign m_icb_cmd_valid = cmd_valid_q;
    assign m_icb_cmd_addr  = cmd_addr_q;
    assign m_icb_cmd_read  = cmd_read_q;
    assign m_icb_cmd_wdata = cmd_wdata_q;
    assign m_icb_cmd_wmask = cmd_wmask_q;
    assign m_icb_rsp_ready = rsp_ready_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_icb_copy_master.sv
// Directed bench for icb_copy_master with a one-outstanding ICB responder.
// Responder read data for address a is {~a[15:0], a[15:0]}.
// Each transaction accepted by the responder is logged as
// {read, wmask, addr, wdata(0 for reads)} and compared with exp_q.
module tb_icb_copy_master;
    import icb_copy_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len_words = '0;
    logic        busy, done, err;
    logic        m_icb_cmd_valid;
    logic        m_icb_cmd_ready = 1'b0;
    logic [31:0] m_icb_cmd_addr;
    logic        m_icb_cmd_read;
    logic [31:0] m_icb_cmd_wdata;
    logic [3:0]  m_icb_cmd_wmask;
    logic        m_icb_rsp_valid = 1'b0;
    logic        m_icb_rsp_ready;
    logic        m_icb_rsp_err = 1'b0;
    logic [31:0] m_icb_rsp_rdata = '0;
    state_e      dbg_state;
`ifdef ICB_COPY_FILL_EN
    logic        fill_mode = 1'b0;
    logic [31:0] fill_data = '0;
`endif

    icb_copy_master dut (
        .clk             (clk),
        .rst             (rst),
`ifdef ICB_COPY_FILL_EN
        .fill_mode       (fill_mode),
        .fill_data       (fill_data),
`endif
        .start           (start),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .len_words       (len_words),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .m_icb_cmd_valid (m_icb_cmd_valid),
        .m_icb_cmd_ready (m_icb_cmd_ready),
        .m_icb_cmd_addr  (m_icb_cmd_addr),
        .m_icb_cmd_read  (m_icb_cmd_read),
        .m_icb_cmd_wdata (m_icb_cmd_wdata),
        .m_icb_cmd_wmask (m_icb_cmd_wmask),
        .m_icb_rsp_valid (m_icb_rsp_valid),
        .m_icb_rsp_ready (m_icb_rsp_ready),
        .m_icb_rsp_err   (m_icb_rsp_err),
        .m_icb_rsp_rdata (m_icb_rsp_rdata),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int vec_cnt = 0;
    int err_cnt = 0;
    logic [68:0] exp_q[$];
    logic [68:0] act_q[$];

    // Responder knobs (written by the test sequence only).
    int ready_wait = 0;
    int err_at_rd  = -1;

    // Responder bookkeeping (written by the responder only).
    int          rd_total   = 0;
    int          wait_cnt   = 0;
    int          stab_checks = 0;
    int          stab_bad   = 0;
    int          rsp_bad    = 0;
    int          done_cnt   = 0;
    bit          rsp_pend   = 0;
    bit          rsp_pend_err = 0;
    logic [31:0] rsp_pend_data = '0;
    logic [68:0] hold_cmd = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [68:0] ent(input logic rd, input logic [3:0] m,
                                        input logic [31:0] a, input logic [31:0] d);
        return {rd, m, a, d};
    endfunction

    // Responder: decisions made on the falling edge, so DUT outputs are
    // settled and responder inputs are stable at the next rising edge.
    always @(negedge clk) begin
        logic [68:0] cur;
        m_icb_cmd_ready = 1'b0;
        m_icb_rsp_valid = 1'b0;
        m_icb_rsp_err   = 1'b0;
        m_icb_rsp_rdata = '0;
        if (done === 1'b1) done_cnt++;
        if (rst) begin
            rsp_pend = 0;
            wait_cnt = 0;
        end else if (rsp_pend) begin
            if (m_icb_rsp_ready !== 1'b1) rsp_bad++;
            m_icb_rsp_valid = 1'b1;
            m_icb_rsp_err   = rsp_pend_err;
            m_icb_rsp_rdata = rsp_pend_data;
            rsp_pend = 0;
        end else if (m_icb_cmd_valid === 1'b1) begin
            cur = ent(m_icb_cmd_read, m_icb_cmd_wmask, m_icb_cmd_addr,
                      m_icb_cmd_read ? 32'h0 : m_icb_cmd_wdata);
            if (wait_cnt == 0) begin
                hold_cmd = cur;
            end else begin
                stab_checks++;
                if (cur !== hold_cmd) stab_bad++;
            end
            if (wait_cnt >= ready_wait) begin
                m_icb_cmd_ready = 1'b1;
                act_q.push_back(cur);
                rsp_pend      = 1;
                rsp_pend_err  = 0;
                rsp_pend_data = '0;
                if (m_icb_cmd_read) begin
                    rd_total++;
                    rsp_pend_data = mem_word(m_icb_cmd_addr);
                    if (rd_total == err_at_rd) rsp_pend_err = 1;
                end
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        src_addr  = s;
        dst_addr  = d;
        len_words = l;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        vec_cnt++;
        if (done !== 1'b1) begin
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, budget);
            err_cnt++;
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        vec_cnt++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); err_cnt++; end
        vec_cnt++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done); err_cnt++; end
        vec_cnt++; if (err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", err); err_cnt++; end
        vec_cnt++; if (m_icb_cmd_valid !== 1'b0) begin $display("FAIL reset_cmd_valid: got %b want 0", m_icb_cmd_valid); err_cnt++; end
        vec_cnt++; if (m_icb_rsp_ready !== 1'b0) begin $display("FAIL reset_rsp_ready: got %b want 0", m_icb_rsp_ready); err_cnt++; end
        vec_cnt++; if (m_icb_cmd_addr !== 32'h0) begin $display("FAIL reset_cmd_addr: got %h want 0", m_icb_cmd_addr); err_cnt++; end
        vec_cnt++; if (m_icb_cmd_wdata !== 32'h0) begin $display("FAIL reset_cmd_wdata: got %h want 0", m_icb_cmd_wdata); err_cnt++; end
        vec_cnt++; if (m_icb_cmd_read !== 1'b0) begin $display("FAIL reset_cmd_read: got %b want 0", m_icb_cmd_read); err_cnt++; end
        vec_cnt++; if (m_icb_cmd_wmask !== 4'h0) begin $display("FAIL reset_wmask: got %h want 0", m_icb_cmd_wmask); err_cnt++; end
        vec_cnt++; if (dbg_state !== IDLE) begin $display("FAIL reset_state: got %0d want IDLE", dbg_state); err_cnt++; end
    endtask

    task automatic test_copy();
        int base = act_q.size();
        int d0 = done_cnt;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ent(1'b1, 4'h0, 32'h100 + 32'(4*i), 32'h0));
            exp_q.push_back(ent(1'b0, 4'hF, 32'h200 + 32'(4*i), mem_word(32'h100 + 32'(4*i))));
        end
        ready_wait = 0;
        start_xfer(32'h100, 32'h200, 16'd4);
        vec_cnt++; if (busy !== 1'b1) begin $display("FAIL copy_busy_after_start: got %b want 1", busy); err_cnt++; end
        wait_done(200, "copy");
        vec_cnt++; if (act_q.size() - base !== exp_q.size()) begin $display("FAIL copy_count: got %0d want %0d", act_q.size() - base, exp_q.size()); err_cnt++; end
        for (int i = 0; i < exp_q.size() && base + i < act_q.size(); i++) begin
            vec_cnt++;
            if (act_q[base+i] !== exp_q[i]) begin $display("FAIL copy_txn%0d: got %h want %h", i, act_q[base+i], exp_q[i]); err_cnt++; end
        end
        vec_cnt++; if (done_cnt - d0 !== 1) begin $display("FAIL copy_done_pulses: got %0d want 1", done_cnt - d0); err_cnt++; end
        vec_cnt++; if (err !== 1'b0) begin $display("FAIL copy_err: got %b want 0", err); err_cnt++; end
        vec_cnt++; if (busy !== 1'b0) begin $display("FAIL copy_busy_end: got %b want 0", busy); err_cnt++; end
    endtask

    task automatic test_stall();
        int base = act_q.size();
        int s0 = stab_checks;
        int b0 = stab_bad;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ent(1'b1, 4'h0, 32'h300 + 32'(4*i), 32'h0));
            exp_q.push_back(ent(1'b0, 4'hF, 32'h400 + 32'(4*i), mem_word(32'h300 + 32'(4*i))));
        end
        ready_wait = 5;
        start_xfer(32'h300, 32'h400, 16'd2);
        wait_done(300, "stall");
        ready_wait = 0;
        vec_cnt++; if (act_q.size() - base !== exp_q.size()) begin $display("FAIL stall_count: got %0d want %0d", act_q.size() - base, exp_q.size()); err_cnt++; end
        for (int i = 0; i < exp_q.size() && base + i < act_q.size(); i++) begin
            vec_cnt++;
            if (act_q[base+i] !== exp_q[i]) begin $display("FAIL stall_txn%0d: got %h want %h", i, act_q[base+i], exp_q[i]); err_cnt++; end
        end
        vec_cnt++; if (stab_checks - s0 !== 20) begin $display("FAIL stall_wait_cycles: got %0d want 20", stab_checks - s0); err_cnt++; end
        vec_cnt++; if (stab_bad - b0 !== 0) begin $display("FAIL stall_cmd_stable: got %0d changes want 0", stab_bad - b0); err_cnt++; end
    endtask

    task automatic test_zero_len();
        int base = act_q.size();
        int d0 = done_cnt;
        start_xfer(32'h700, 32'h800, 16'd0);
        vec_cnt++; if (busy !== 1'b1) begin $display("FAIL zlen_busy_c1: got %b want 1", busy); err_cnt++; end
        vec_cnt++; if (done !== 1'b1) begin $display("FAIL zlen_done_c1: got %b want 1", done); err_cnt++; end
        vec_cnt++; if (m_icb_cmd_valid !== 1'b0) begin $display("FAIL zlen_cmd_valid: got %b want 0", m_icb_cmd_valid); err_cnt++; end
        @(posedge clk); #1;
        vec_cnt++; if (busy !== 1'b0) begin $display("FAIL zlen_busy_c2: got %b want 0", busy); err_cnt++; end
        vec_cnt++; if (done !== 1'b0) begin $display("FAIL zlen_done_c2: got %b want 0", done); err_cnt++; end
        repeat (4) begin @(posedge clk); #1; end
        vec_cnt++; if (act_q.size() - base !== 0) begin $display("FAIL zlen_no_traffic: got %0d txns want 0", act_q.size() - base); err_cnt++; end
        vec_cnt++; if (done_cnt - d0 !== 1) begin $display("FAIL zlen_done_pulses: got %0d want 1", done_cnt - d0); err_cnt++; end
    endtask

    task automatic test_error();
        int base = act_q.size();
        int d0 = done_cnt;
        exp_q.delete();
        exp_q.push_back(ent(1'b1, 4'h0, 32'h500, 32'h0));
        exp_q.push_back(ent(1'b0, 4'hF, 32'h600, mem_word(32'h500)));
        exp_q.push_back(ent(1'b1, 4'h0, 32'h504, 32'h0));
        err_at_rd = rd_total + 2;
        start_xfer(32'h500, 32'h600, 16'd4);
        wait_done(200, "error");
        err_at_rd = -1;
        vec_cnt++; if (act_q.size() - base !== 3) begin $display("FAIL err_count: got %0d want 3", act_q.size() - base); err_cnt++; end
        for (int i = 0; i < exp_q.size() && base + i < act_q.size(); i++) begin
            vec_cnt++;
            if (act_q[base+i] !== exp_q[i]) begin $display("FAIL err_txn%0d: got %h want %h", i, act_q[base+i], exp_q[i]); err_cnt++; end
        end
        vec_cnt++; if (err !== 1'b1) begin $display("FAIL err_sticky: got %b want 1", err); err_cnt++; end
        vec_cnt++; if (done_cnt - d0 !== 1) begin $display("FAIL err_done_pulses: got %0d want 1", done_cnt - d0); err_cnt++; end
        // A fresh start clears the sticky error on acceptance.
        start_xfer(32'h900, 32'hA00, 16'd1);
        vec_cnt++; if (err !== 1'b0) begin $display("FAIL err_clear_on_start: got %b want 0", err); err_cnt++; end
        wait_done(100, "err_next");
        vec_cnt++; if (err !== 1'b0) begin $display("FAIL err_next_clean: got %b want 0", err); err_cnt++; end
    endtask

    task automatic test_wrap_and_busy_start();
        int base = act_q.size();
        int d0 = done_cnt;
        exp_q.delete();
        exp_q.push_back(ent(1'b1, 4'h0, 32'hFFFF_FFFC, 32'h0));
        exp_q.push_back(ent(1'b0, 4'hF, 32'h0000_0800, mem_word(32'hFFFF_FFFC)));
        exp_q.push_back(ent(1'b1, 4'h0, 32'h0000_0000, 32'h0));
        exp_q.push_back(ent(1'b0, 4'hF, 32'h0000_0804, mem_word(32'h0000_0000)));
        // Low address bits are dropped: 0xFFFF_FFFF -> 0xFFFF_FFFC, 0x802 -> 0x800.
        start_xfer(32'hFFFF_FFFF, 32'h0000_0802, 16'd2);
        @(posedge clk); #1;
        start_xfer(32'h0000_1234, 32'h0000_5678, 16'd0);
        wait_done(200, "wrap");
        vec_cnt++; if (act_q.size() - base !== exp_q.size()) begin $display("FAIL wrap_count: got %0d want %0d", act_q.size() - base, exp_q.size()); err_cnt++; end
        for (int i = 0; i < exp_q.size() && base + i < act_q.size(); i++) begin
            vec_cnt++;
            if (act_q[base+i] !== exp_q[i]) begin $display("FAIL wrap_txn%0d: got %h want %h", i, act_q[base+i], exp_q[i]); err_cnt++; end
        end
        vec_cnt++; if (done_cnt - d0 !== 1) begin $display("FAIL wrap_done_pulses: got %0d want 1", done_cnt - d0); err_cnt++; end
    endtask

    task automatic test_reset_mid();
        start_xfer(32'h1000, 32'h2000, 16'd4);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (busy !== 1'b0) begin $display("FAIL midrst_busy: got %b want 0", busy); err_cnt++; end
        vec_cnt++; if (m_icb_cmd_valid !== 1'b0) begin $display("FAIL midrst_cmd_valid: got %b want 0", m_icb_cmd_valid); err_cnt++; end
        vec_cnt++; if (m_icb_rsp_ready !== 1'b0) begin $display("FAIL midrst_rsp_ready: got %b want 0", m_icb_rsp_ready); err_cnt++; end
        vec_cnt++; if (m_icb_cmd_addr !== 32'h0) begin $display("FAIL midrst_cmd_addr: got %h want 0", m_icb_cmd_addr); err_cnt++; end
        vec_cnt++; if (dbg_state !== IDLE) begin $display("FAIL midrst_state: got %0d want IDLE", dbg_state); err_cnt++; end
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

`ifdef ICB_COPY_FILL_EN
    task automatic test_fill();
        int base = act_q.size();
        exp_q.delete();
        for (int i = 0; i < 3; i++)
            exp_q.push_back(ent(1'b0, 4'hF, 32'h40 + 32'(4*i), 32'hA5A5_A5A5));
        fill_mode = 1'b1;
        fill_data = 32'hA5A5_A5A5;
        start_xfer(32'h999, 32'h40, 16'd3);
        fill_mode = 1'b0;
        fill_data = '0;
        wait_done(200, "fill");
        vec_cnt++; if (act_q.size() - base !== 3) begin $display("FAIL fill_count: got %0d want 3", act_q.size() - base); err_cnt++; end
        for (int i = 0; i < exp_q.size() && base + i < act_q.size(); i++) begin
            vec_cnt++;
            if (act_q[base+i] !== exp_q[i]) begin $display("FAIL fill_txn%0d: got %h want %h", i, act_q[base+i], exp_q[i]); err_cnt++; end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_copy();
        test_stall();
        test_zero_len();
        test_error();
        test_wrap_and_busy_start();
        test_reset_mid();
`ifdef ICB_COPY_FILL_EN
        test_fill();
`endif
        vec_cnt++; if (rsp_bad !== 0) begin $display("FAIL rsp_ready_during_rsp: got %0d misses want 0", rsp_bad); err_cnt++; end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
